// File: rtl/ddr_port0_writer.sv
// Packs raster-order pixel words into MCB port-0 write bursts.
// Define DDR_WR_FRAME_SWAP_EN for double-buffered frames at FRAME1_BASE.
module ddr_port0_writer #(
  parameter int          BURST_LEN   = 64,
  parameter logic [29:0] FRAME1_BASE = 30'h0050_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_calib_done,
  input  logic [3:0]  resolution,
  input  logic        update,
  input  logic [31:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        wr_en,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_mask,
  input  logic        wr_full,
  input  logic        cmd_full,
  output logic        cmd_en,
  output logic [2:0]  cmd_instr,
  output logic [5:0]  cmd_bl,
  output logic [29:0] cmd_byte_addr,
  output logic        frame_done,
  output logic        frame_sel
);

`ifdef DDR_WR_FRAME_SWAP_EN
  localparam bit SWAP_EN = 1'b1;
`else
  localparam bit SWAP_EN = 1'b0;
`endif

  localparam logic [6:0] BL = 7'(BURST_LEN);

  typedef enum logic [1:0] {
    CALIB,
    FILL,
    CMD
  } state_t;

  state_t      state;
  logic        calib_s1;
  logic        calib_s2;
  logic [20:0] total_pixels;
  logic [20:0] pending_total;
  logic [20:0] pix_index;
  logic [6:0]  burst_cnt;
  logic [29:0] burst_addr;
  logic        last_burst;
  logic        sel;

  logic [20:0] res_total;
  logic        is_last;
  logic        accept;
  logic        closing;
  logic        issue;
  logic [29:0] cur_base;
  logic [29:0] nxt_base;

  always_comb begin
    unique case (resolution)
      4'b0000: res_total = 21'd307200;
      4'b0001: res_total = 21'd480000;
      4'b0011: res_total = 21'd786432;
      4'b0010: res_total = 21'd921600;
      default: res_total = 21'd1310720;
    endcase
  end

  assign is_last   = pix_index == total_pixels - 21'd1;
  assign pix_ready = (state == FILL) && !wr_full
                     && (burst_cnt < BL);
  assign accept    = pix_ready && pix_valid;
  assign closing   = accept
                     && ((burst_cnt == BL - 7'd1) || is_last);
  assign issue     = (state == CMD) && !cmd_full;

  assign wr_en     = accept;
  assign wr_data   = pix_data;
  assign wr_mask   = 4'b0000;
  assign cmd_instr = 3'b000;
  assign cmd_en    = issue;
  assign cmd_bl    = (state == CMD)
                     ? burst_cnt[5:0] - 6'd1 : 6'd0;
  assign cmd_byte_addr = (state == CMD) ? burst_addr : 30'd0;
  assign frame_done    = issue && last_burst;
  assign frame_sel     = sel;

  // the next frame's base follows the buffer toggle
  assign cur_base = sel ? FRAME1_BASE : 30'd0;
  assign nxt_base = (sel ^ SWAP_EN) ? FRAME1_BASE : 30'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= CALIB;
      calib_s1      <= 1'b0;
      calib_s2      <= 1'b0;
      total_pixels  <= 21'd307200;
      pending_total <= 21'd307200;
      pix_index     <= 21'd0;
      burst_cnt     <= 7'd0;
      burst_addr    <= 30'd0;
      last_burst    <= 1'b0;
      sel           <= 1'b0;
    end else begin
      calib_s1 <= mem_calib_done;
      calib_s2 <= calib_s1;
      if (update) pending_total <= res_total;
      unique case (state)
        CALIB: begin
          total_pixels <= pending_total;
          if (calib_s2) state <= FILL;
        end
        FILL: begin
          if (accept) begin
            burst_cnt <= burst_cnt + 7'd1;
            pix_index <= pix_index + 21'd1;
            if (closing) begin
              state      <= CMD;
              last_burst <= is_last;
            end
          end
        end
        CMD: begin
          if (!cmd_full) begin
            state     <= FILL;
            burst_cnt <= 7'd0;
            if (last_burst) begin
              pix_index    <= 21'd0;
              burst_addr   <= nxt_base;
              total_pixels <= pending_total;
              last_burst   <= 1'b0;
              sel          <= sel ^ SWAP_EN;
            end else begin
              burst_addr <= cur_base
                            + {7'd0, pix_index, 2'b00};
            end
          end
        end
        default: state <= CALIB;
      endcase
    end
  end

endmodule

// File: doc/ddr_port0_writer.md
# ddr_port0_writer

Upstream neighbour of the port-1 DDR read controller. It accepts Mandelbrot iteration results, one 32-bit word per pixel in raster order, through a valid/ready handshake. It packs them into bursts on MCB port 0 (write FIFO plus command path), with byte address = pixel_index × 4. This produces the frame image that the port-1 controller streams to HDMI.

## Interface
Parameters:
- BURST_LEN, 64 — maximum words per write command (1..64).
- FRAME1_BASE, 30'h0050_0000 — byte base of the second frame buffer; used only with DDR_WR_FRAME_SWAP_EN.

Ports:
- clk  in  1  MCB user clock; single clock domain.
- reset  in  1  asynchronous, active-high.
- mem_calib_done  in  1  MCB calibration flag; async, 2-flop synchronised internally.
- resolution  in  4  VGA 0000, SVGA 0001, XGA 0011, 720p 0010; any other code means SXGA.
- update  in  1  1-cycle pulse that latches resolution.
- pix_data  in  32  iteration count.
- pix_valid  in  1  pix_data is valid.
- pix_ready  out  1  block accepts a word this cycle.
- wr_en  out  1  MCB write-FIFO push.
- wr_data  out  32  equals pix_data.
- wr_mask  out  4  constant 4'b0000.
- wr_full  in  1  MCB write FIFO full.
- cmd_full  in  1  MCB command FIFO full.
- cmd_en  out  1  command strobe.
- cmd_instr  out  3  constant 3'b000 (write).
- cmd_bl  out  6  burst length − 1.
- cmd_byte_addr  out  30  burst start byte address.
- frame_done  out  1  1-cycle pulse when a frame's last command is issued.
- frame_sel  out  1  buffer currently written; tied 0 without the macro.

## Operation
- total_pixels is 21 bits wide: 307200, 480000, 786432, 921600 or 1310720. Reset value is 307200 (VGA).
- update latches the decoded resolution into pending_total. pending_total is copied to total_pixels only at a frame boundary (pix_index wrap) or in CALIB. An update in mid-frame never truncates the current frame.
- Counters:
  - pix_index, 21 bits: next pixel to accept.
  - burst_cnt, 7 bits: words pushed in the current burst.
  - burst_addr, 30 bits: equals {pix_index at burst start, 2'b00} (+ base).
- State machine:
  - CALIB: hold until the synchronised calib flag is 1, then go to FILL.
  - FILL: pix_ready = !wr_full && burst_cnt < BURST_LEN. wr_en = pix_valid & pix_ready (combinational, same cycle). On each accept, increment burst_cnt and increment pix_index. The burst closes when burst_cnt reaches BURST_LEN or the accepted word is pixel total_pixels−1; then go to CMD.
  - CMD: pix_ready = 0. When cmd_full = 0, assert cmd_en for 1 cycle with cmd_bl = burst_cnt−1 and cmd_byte_addr = burst_addr. Then clear burst_cnt, set burst_addr to the new pix_index × 4, and return to FILL.
  - If the burst held the last pixel, CMD also wraps pix_index to 0, pulses frame_done on the same cycle as cmd_en, and applies pending_total.
- A last pixel that also fills the burst produces one command only, not two.
- A command is never issued with zero words; its data is always already in the MCB FIFO.
- Once in FILL/CMD, the block ignores a drop of calib_done. Only reset returns it to CALIB.

## Timing
- Reset values:
  - outputs: pix_ready 0, wr_en 0, cmd_en 0, frame_done 0, frame_sel 0, cmd_bl 0, cmd_byte_addr 0, cmd_instr 0.
  - state: CALIB, pix_index 0, burst_cnt 0.
- CALIB exit: 2 cycles after mem_calib_done rises (synchroniser), then 1 cycle into FILL.
- Data path latency is 0: a word accepted on edge N is in the MCB FIFO on edge N.
- cmd_en is asserted at the earliest on the first cycle after the closing word. cmd_full stalls CMD indefinitely, with no word lost.
- Peak throughput: BURST_LEN words per BURST_LEN+1 cycles.
- Reset mid-burst: abort immediately and discard the partial burst count. No cmd_en is issued for it.

## Configuration
- DDR_WR_FRAME_SWAP_EN defined: double buffering.
  - Addresses are offset by FRAME1_BASE while frame_sel = 1.
  - frame_sel toggles on the cycle after the frame_done pulse.
  - The reader selects its buffer with !frame_sel.
- Undefined: there is a single buffer at base 0, and frame_sel stays constant 0.

## Test plan
- calib low, pix_valid = 1 → pix_ready = 0 and wr_en never asserts. calib rises → first accept at the 3rd or 4th edge.
- VGA, 64 consecutive valid words → cmd_en once with cmd_bl = 63 and cmd_byte_addr = 0. The next burst gets cmd_byte_addr = 256.
- BURST_LEN = 7, VGA, full frame → last command has cmd_bl = 4 (5 words) at byte address 1228780. frame_done coincides with it, and the next burst starts at address 0.
- cmd_full held high 20 cycles in CMD → pix_ready = 0 and cmd_en = 0 throughout. Single cmd_en after release, and no data lost.
- update to SXGA at pixel 1000 of a VGA frame → the frame still ends at 307200. The next frame ends at 1310720.
- Reset asserted mid-burst (burst_cnt = 30) → all outputs 0 asynchronously, and no cmd_en. After recalibration the first burst addresses 0. With the macro, frame_sel alternates and the second frame's first address is 0x0050_0000.
